// File: rtl/approx_err_monitor_if.sv
// Sample/report bundle between the approximate adder path and its error monitor.
// The slave modport is the monitor; the master modport is the producer/consumer side.
interface approx_err_monitor_if #(
  parameter int N  = 32,
  parameter int CW = 7
) ();
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_a;
  logic [N-1:0]  in_b;
  logic [N-1:0]  in_sum;
  logic [CW-1:0] thr_cnt;
  logic          rpt_valid;
  logic          rpt_ready;
  logic [CW-1:0] rpt_err_cnt;
  logic [N+CW-1:0] rpt_err_sum;
  logic [N-1:0]  rpt_max_err;
  logic          exact_req;

  modport slave (
    input  in_valid, in_a, in_b, in_sum, thr_cnt, rpt_ready,
    output in_ready, rpt_valid, rpt_err_cnt, rpt_err_sum, rpt_max_err, exact_req
  );

  modport master (
    output in_valid, in_a, in_b, in_sum, thr_cnt, rpt_ready,
    input  in_ready, rpt_valid, rpt_err_cnt, rpt_err_sum, rpt_max_err, exact_req
  );
endinterface

// File: rtl/approx_err_monitor.sv
// Error-statistics monitor for the truncated approximate adder: accumulates per-window error
// count, sum and maximum, reports once per WIN samples and requests exact mode on too many errors.
module approx_err_monitor #(
  parameter int N   = 32,
  parameter int WIN = 64,
  localparam int CW = $clog2(WIN + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  approx_err_monitor_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_ACCUM  = 1'b0,
    ST_REPORT = 1'b1
  } state_t;

  localparam logic [CW-1:0] LAST_CNT = CW'(WIN - 1);

  state_t          state_r;
  state_t          state_nxt_s;
  logic [CW-1:0]   smp_cnt_r;
  logic [CW-1:0]   err_cnt_r;
  logic [N+CW-1:0] err_sum_r;
  logic [N-1:0]    max_err_r;
  logic [CW-1:0]   rpt_err_cnt_r;
  logic [N+CW-1:0] rpt_err_sum_r;
  logic [N-1:0]    rpt_max_err_r;
  logic            exact_req_r;

  logic [N-1:0]    err_s;
  logic            accept_s;
  logic            last_s;
  logic            rpt_done_s;
  logic [CW-1:0]   err_cnt_nxt_s;
  logic [N+CW-1:0] err_sum_nxt_s;
  logic [N-1:0]    max_err_nxt_s;

  // Carry-out of a+b is dropped by the N-bit result, so an identically wrapped sum gives 0.
  function automatic logic [N-1:0] calc_err(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [N-1:0] s);
    return a + b - s;
  endfunction

  // Handshake decode and the accumulator values after including the current sample.
  always_comb begin
    err_s         = calc_err(bus.in_a, bus.in_b, bus.in_sum);
    accept_s      = (state_r == ST_ACCUM) && bus.in_valid;
    last_s        = accept_s && (smp_cnt_r == LAST_CNT);
    rpt_done_s    = (state_r == ST_REPORT) && bus.rpt_ready;
    err_cnt_nxt_s = err_cnt_r + {{(CW-1){1'b0}}, (err_s != {N{1'b0}})};
    err_sum_nxt_s = err_sum_r + {{CW{1'b0}}, err_s};
    if (err_s > max_err_r) begin
      max_err_nxt_s = err_s;
    end else begin
      max_err_nxt_s = max_err_r;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_ACCUM;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_ACCUM: begin
        if (last_s) begin
          state_nxt_s = ST_REPORT;
        end else begin
          state_nxt_s = ST_ACCUM;
        end
      end
      ST_REPORT: begin
        if (rpt_done_s) begin
          state_nxt_s = ST_ACCUM;
        end else begin
          state_nxt_s = ST_REPORT;
        end
      end
      default: state_nxt_s = ST_ACCUM;
    endcase
  end

  // Window accumulators, report registers and the exact-mode request.
  always_ff @(posedge clk) begin
    if (rst) begin
      smp_cnt_r     <= {CW{1'b0}};
      err_cnt_r     <= {CW{1'b0}};
      err_sum_r     <= {(N+CW){1'b0}};
      max_err_r     <= {N{1'b0}};
      rpt_err_cnt_r <= {CW{1'b0}};
      rpt_err_sum_r <= {(N+CW){1'b0}};
      rpt_max_err_r <= {N{1'b0}};
      exact_req_r   <= 1'b0;
    end else begin
      if (rpt_done_s) begin
        smp_cnt_r <= {CW{1'b0}};
        err_cnt_r <= {CW{1'b0}};
        err_sum_r <= {(N+CW){1'b0}};
        max_err_r <= {N{1'b0}};
      end else if (accept_s) begin
        smp_cnt_r <= smp_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        err_cnt_r <= err_cnt_nxt_s;
        err_sum_r <= err_sum_nxt_s;
        max_err_r <= max_err_nxt_s;
      end
      // The closing sample is folded into the report directly, not via the accumulators.
      if (last_s) begin
        rpt_err_cnt_r <= err_cnt_nxt_s;
        rpt_err_sum_r <= err_sum_nxt_s;
        rpt_max_err_r <= max_err_nxt_s;
        exact_req_r   <= (err_cnt_nxt_s > bus.thr_cnt);
      end
    end
  end

  assign bus.in_ready    = (state_r == ST_ACCUM);
  assign bus.rpt_valid   = (state_r == ST_REPORT);
  assign bus.rpt_err_cnt = rpt_err_cnt_r;
  assign bus.rpt_err_sum = rpt_err_sum_r;
  assign bus.rpt_max_err = rpt_max_err_r;
  assign bus.exact_req   = exact_req_r;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Scoreboard bench for approx_err_monitor (N=32, WIN=4): a window-level reference model
// predicts reports and control outputs; a separate monitor pops and compares reports.
module tb_approx_err_monitor;

  localparam int N   = 32;
  localparam int WIN = 4;
  localparam int CW  = $clog2(WIN + 1);

  typedef struct {
    int              cnt;
    longint unsigned sum;
    longint unsigned mx;
  } rpt_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  bit   chk_en;
  bit   m_in_report;
  bit   m_exact;
  bit   have_cur;
  rpt_t cur;
  rpt_t exp_q[$];
  longint unsigned win_errs[$];

  approx_err_monitor_if #(.N(N), .CW(CW)) bus ();

  approx_err_monitor #(.N(N), .WIN(WIN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint unsigned ref_err(input longint unsigned a, input longint unsigned b,
                                              input longint unsigned s);
    return (a + b + 64'h2_0000_0000 - s) % 64'h1_0000_0000;
  endfunction

  // Reference model: per-cycle control expectations plus window totals pushed on close.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("in_ready", 64'(bus.in_ready), 64'(!m_in_report));
        chk("rpt_valid", 64'(bus.rpt_valid), 64'(m_in_report));
        chk("exact_req", 64'(bus.exact_req), 64'(m_exact));
      end
      if (rst) begin
        m_in_report = 1'b0;
        m_exact     = 1'b0;
        win_errs.delete();
      end else if (m_in_report) begin
        if (bus.rpt_ready) m_in_report = 1'b0;
      end else if (bus.in_valid) begin
        win_errs.push_back(ref_err(64'(bus.in_a), 64'(bus.in_b), 64'(bus.in_sum)));
        if (win_errs.size() == WIN) begin
          rpt_t r;
          r.cnt = 0;
          r.sum = 0;
          r.mx  = 0;
          foreach (win_errs[i]) begin
            if (win_errs[i] != 0) r.cnt++;
            r.sum += win_errs[i];
            if (win_errs[i] > r.mx) r.mx = win_errs[i];
          end
          exp_q.push_back(r);
          m_exact     = (r.cnt > int'(bus.thr_cnt));
          m_in_report = 1'b1;
          win_errs.delete();
        end
      end
    end
  end

  // Report monitor: pops an expectation when a report appears and checks it every cycle it is held.
  initial begin
    have_cur = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        have_cur = 1'b0;
      end else if (chk_en && bus.rpt_valid) begin
        if (!have_cur) begin
          if (exp_q.size() == 0) begin
            chk("rpt_unexpected", 64'(bus.rpt_valid), 64'd0);
          end else begin
            cur      = exp_q.pop_front();
            have_cur = 1'b1;
          end
        end
        if (have_cur) begin
          chk("rpt_err_cnt", 64'(bus.rpt_err_cnt), 64'(cur.cnt));
          chk("rpt_err_sum", 64'(bus.rpt_err_sum), cur.sum);
          chk("rpt_max_err", 64'(bus.rpt_max_err), cur.mx);
          if (bus.rpt_ready) have_cur = 1'b0;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_err_cnt", 64'(bus.rpt_err_cnt), 64'd0);
    chk("rst_err_sum", 64'(bus.rpt_err_sum), 64'd0);
    chk("rst_max_err", 64'(bus.rpt_max_err), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] b, input logic [31:0] s);
    bit ok;
    ok = 1'b0;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sum   = s;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) chk("put_timeout", 64'(ok), 64'd1);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    chk_en        = 1'b0;
    m_in_report   = 1'b0;
    m_exact       = 1'b0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = 32'd0;
    bus.in_b      = 32'd0;
    bus.in_sum    = 32'd0;
    bus.thr_cnt   = 3'd3;
    bus.rpt_ready = 1'b1;
    do_reset();

    // 1: exact samples
    repeat (4) put(32'd5, 32'd7, 32'd12);
    idle(3);

    // 2: three errors of 0x100 against threshold 1
    bus.thr_cnt = 3'd1;
    repeat (3) put(32'h0FF, 32'h001, 32'h000);
    put(32'd3, 32'd4, 32'd7);
    idle(3);

    // 3: report stall with in_valid held high
    bus.rpt_ready = 1'b0;
    repeat (4) put(32'd10, 32'd20, 32'd28);
    bus.in_valid = 1'b1;
    bus.in_a     = 32'h1234;
    bus.in_b     = 32'h1;
    bus.in_sum   = 32'h0;
    idle(10);
    bus.in_valid  = 1'b0;
    bus.rpt_ready = 1'b1;
    idle(2);
    repeat (4) put(32'd1, 32'd1, 32'd2);
    idle(3);

    // 4: threshold equality, above, then clean
    bus.thr_cnt = 3'd2;
    put(32'd1, 32'd1, 32'd3);
    put(32'd1, 32'd1, 32'd3);
    put(32'd1, 32'd1, 32'd2);
    put(32'd1, 32'd1, 32'd2);
    idle(3);
    repeat (3) put(32'd100, 32'd50, 32'd140);
    put(32'd1, 32'd1, 32'd2);
    idle(3);
    repeat (4) put(32'd9, 32'd9, 32'd18);
    idle(3);

    // 5: reset mid-window, then reset during a held report with exact_req set
    put(32'd1, 32'd1, 32'd0);
    put(32'd1, 32'd1, 32'd0);
    do_reset();
    repeat (4) put(32'd2, 32'd2, 32'd4);
    idle(3);
    bus.thr_cnt   = 3'd0;
    bus.rpt_ready = 1'b0;
    repeat (4) put(32'd8, 32'd8, 32'd1);
    idle(2);
    do_reset();
    bus.rpt_ready = 1'b1;
    idle(2);

    // 6: wrap-around with gapped in_valid
    repeat (4) begin
      put(32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
      idle(2);
    end
    idle(3);

    // Random traffic with random report back-pressure and thresholds
    for (int i = 0; i < 400; i++) begin
      bus.rpt_ready = ($urandom_range(0, 2) != 0);
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.in_a      = $urandom;
      bus.in_b      = $urandom;
      bus.in_sum    = ($urandom_range(0, 1) == 0) ? (bus.in_a + bus.in_b) : 32'($urandom);
      if ($urandom_range(0, 15) == 0) bus.thr_cnt = 3'($urandom_range(0, 4));
      idle(1);
    end
    bus.in_valid  = 1'b0;
    bus.rpt_ready = 1'b1;
    idle(10);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
